// File: rtl/lsu_subword.sv
// rtl/lsu_subword.sv - RV32I byte/halfword/word load-store unit in front of a word-only data memory.
// Define LSU_MISALIGN_TRAP_EN to report misaligned halfword/word accesses as errors.
module lsu_subword #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, LD, RMW_RD, WR, RESP} state_t;

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_t      state, state_nxt;
    logic        we_q, err_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, merge_q, rdata_q;

    logic        accept, f3_ok, range_ok, align_ok, req_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext, wr_data;

    assign accept = req_valid && (state == IDLE);

    always_comb begin
        f3_ok = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'd0, 3'd1, 3'd2: f3_ok = 1'b1;
                default:          f3_ok = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: f3_ok = 1'b1;
                default:                      f3_ok = 1'b0;
            endcase
        end
        range_ok = (req_addr[31:2] < WORD_LIMIT);
`ifdef LSU_MISALIGN_TRAP_EN
        case (req_funct3[1:0])
            2'b01:   align_ok = (req_addr[0] == 1'b0);
            2'b10:   align_ok = (req_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
`else
        align_ok = 1'b1;
`endif
        req_err = !(f3_ok && range_ok && align_ok);
    end

    // Lane extraction for loads and lane insertion for sub-word stores
    always_comb begin
        ld_byte = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_ext = {24'h0, ld_byte};
            3'd5:    ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
        wr_data = merge_q;
        case (f3_q[1:0])
            2'b00: begin
                case (addr_q[1:0])
                    2'd0: wr_data[7:0]   = wdata_q[7:0];
                    2'd1: wr_data[15:8]  = wdata_q[7:0];
                    2'd2: wr_data[23:16] = wdata_q[7:0];
                    2'd3: wr_data[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) wr_data[31:16] = wdata_q[15:0];
                else           wr_data[15:0]  = wdata_q[15:0];
            end
            default: wr_data = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (req_err)                     state_nxt = RESP;
                    else if (!req_we)                state_nxt = LD;
                    else if (req_funct3[1:0] == 2'b10) state_nxt = WR;
                    else                             state_nxt = RMW_RD;
                end
            end
            LD: begin
                mem_read  = !rst;
                state_nxt = RESP;
            end
            RMW_RD: begin
                mem_read  = !rst;
                state_nxt = WR;
            end
            WR: begin
                mem_write = !rst;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_addr   = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata  = mem_write ? wr_data : 32'h0;
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;
    assign resp_err   = resp_valid && err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                err_q   <= req_err;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= 32'h0;
            end
            if (state == LD)     rdata_q <= ld_ext;
            if (state == RMW_RD) merge_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_lsu_subword.sv
// tb/tb_lsu_subword.sv - Scoreboard bench for lsu_subword with a behavioural word memory.
module tb_lsu_subword;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    lsu_subword #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [31:0] tb_mem [0:255];
    assign mem_rdata = tb_mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_write) tb_mem[mem_addr[9:2]] <= mem_wdata;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_read)              rd_cnt++;
        if (mem_write)             wr_cnt++;
        if (mem_read && mem_write) both_cnt++;
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                chk("stray_resp", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                chk("resp_rdata", resp_rdata, e.rdata);
            end
        end
    end

    task automatic wait_ready();
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic xerr, input logic [31:0] xdata,
                          input int xlat, input int xrd, input int xwr);
        int lat;
        exp_t x;
        wait_ready();
        x.err = xerr;
        x.rdata = xdata;
        sb_q.push_back(x);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'd7;
        req_addr = 32'hDEAD_BEEF; req_wdata = 32'h5A5A_5A5A;
        rd_cnt = 0;
        wr_cnt = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 10);
        if (!resp_valid) $display("FAIL %s_timeout: got no response expected response", name);
        chk({name, "_latency"}, 32'(lat), 32'(xlat));
        chk({name, "_reads"}, 32'(rd_cnt), 32'(xrd));
        chk({name, "_writes"}, 32'(wr_cnt), 32'(xwr));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_mem_strobes", {30'h0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        rst = 1'b0;

        do_req("sw10",   1'b1, 3'd2, 32'h10, 32'h8899AABC, 1'b0, 32'h0,        2, 0, 1);
        do_req("lw10",   1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'h8899AABC, 2, 1, 0);
        do_req("lb13",   1'b0, 3'd0, 32'h13, 32'h0,        1'b0, 32'hFFFFFF88, 2, 1, 0);
        do_req("lbu13",  1'b0, 3'd4, 32'h13, 32'h0,        1'b0, 32'h00000088, 2, 1, 0);
        do_req("lh12",   1'b0, 3'd1, 32'h12, 32'h0,        1'b0, 32'hFFFF8899, 2, 1, 0);
        do_req("lhu10",  1'b0, 3'd5, 32'h10, 32'h0,        1'b0, 32'h0000AABC, 2, 1, 0);
        do_req("lb10",   1'b0, 3'd0, 32'h10, 32'h0,        1'b0, 32'hFFFFFFBC, 2, 1, 0);
        do_req("sb11",   1'b1, 3'd0, 32'h11, 32'hFFFFFF55, 1'b0, 32'h0,        3, 1, 1);
        do_req("lw_sb",  1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'h889955BC, 2, 1, 0);
        do_req("sh12",   1'b1, 3'd1, 32'h12, 32'hABCD1234, 1'b0, 32'h0,        3, 1, 1);
        do_req("lw_sh",  1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'h123455BC, 2, 1, 0);
        do_req("lw400",  1'b0, 3'd2, 32'h400, 32'h0,       1'b1, 32'h0,        1, 0, 0);
        do_req("ld_f3",  1'b0, 3'd3, 32'h10, 32'h0,        1'b1, 32'h0,        1, 0, 0);
        do_req("st_f3",  1'b1, 3'd4, 32'h10, 32'h1,        1'b1, 32'h0,        1, 0, 0);
        do_req("lw3fc",  1'b0, 3'd2, 32'h3FC, 32'h0,       1'b0, 32'h0,        2, 1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("lh11",   1'b0, 3'd1, 32'h11, 32'h0,        1'b1, 32'h0,        1, 0, 0);
`else
        do_req("lh11",   1'b0, 3'd1, 32'h11, 32'h0,        1'b0, 32'h000055BC, 2, 1, 0);
`endif

        // Abort an SB during its write cycle
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'h20; req_wdata = 32'h000000AA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_rmw_read", {31'h0, mem_read}, 32'd1);
        @(negedge clk);
        chk("abort_in_wr", {31'h0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_write_gated", {31'h0, mem_write}, 32'd0);
        chk("abort_addr_gated", mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready_after", {31'h0, req_ready}, 32'd1);
        chk("abort_no_resp", {31'h0, resp_valid}, 32'd0);
        do_req("lw20",   1'b0, 3'd2, 32'h20, 32'h0,        1'b0, 32'h0,        2, 1, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        chk("no_read_write_overlap", 32'(both_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_subword.md
# lsu_subword

Load/store unit between the pipeline MEM stage and the word-only data memory (256 x 32, combinational read, write on posedge, word index addr>>2). Adds RV32I byte/halfword semantics:
- LB, LH, LW, LBU and LHU loads use a single word read, then lane extraction and sign or zero extension.
- SB and SH stores use a read-modify-write sequence.
- SW uses a direct word write.

Alignment and range are checked before any memory access.

## Interface
- MEM_WORDS, 256, data memory depth in words; byte addresses >= 4*MEM_WORDS are out of range.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; transfer on req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3.
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
  - Other codes are illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: illegal funct3, out-of-range address, or misaligned access (see Configuration).
- mem_read  out  1  to data memory.
- mem_write  out  1  to data memory.
- mem_addr  out  32  always word-aligned ({addr[31:2],2'b00}).
- mem_wdata  out  32  to data memory.
- mem_rdata  in  32  from data memory, combinational.

## Operation
- States: IDLE, LD, RMW_RD, WR, RESP.
- Accept: registers we, funct3, addr, wdata. Next state:
  - RESP with err=1 on error.
  - LD for a load.
  - WR for SW.
  - RMW_RD for SB/SH.
- LD: mem_read=1. At end of cycle, the selected lane is captured into resp_rdata.
  - Byte lane is addr[1:0]: 0 = bits 7:0, 3 = bits 31:24.
  - Halfword lane is addr[1]: 0 = bits 15:0, 1 = bits 31:16.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - Next state: RESP.
- RMW_RD: mem_read=1. mem_rdata is captured into the merge register. Next state: WR.
- WR: mem_write=1.
  - mem_wdata is wdata for SW.
  - For SB/SH, mem_wdata is the merge register with only the addressed lane replaced.
  - Next state: RESP.
- RESP: resp_valid=1. Next state: IDLE. There is no response backpressure; the consumer must sample the pulse.
- mem_read and mem_write are never high together. Both are 0 in IDLE and RESP.
- An error request never drives mem_read or mem_write.
- mem_addr and mem_wdata are 0 when not strobed.

## Timing
- Reset values: state IDLE, req_ready=1, all other outputs 0, internal registers 0.
- Reset mid-operation: the FSM goes to IDLE at the edge. Memory strobes are gated to 0 combinationally while rst=1, so a pending WR never writes. No response is produced for the aborted request.
- Latency from the accept edge to the resp_valid cycle:
  - Load and SW: resp_valid 2 cycles after the accept edge.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- The next accept is possible the cycle after RESP.
  - Throughput: one load or SW every 3 cycles; one SB/SH every 4 cycles.
- The memory write lands on the posedge ending the WR cycle. A load issued after that response observes the new data.
- Inputs are ignored outside IDLE, and req_* may change freely while req_ready=0.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned requests respond with resp_err=1 and no memory access.
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- Undefined:
  - Alignment is not checked.
  - Halfword accesses use addr[1] and ignore addr[0].
  - Word accesses ignore addr[1:0].
  - Illegal funct3 and out-of-range addresses still set resp_err.

## Test plan
- SW addr 0x10 data 0x8899AABC, then LW 0x10 -> resp_rdata 0x8899AABC. SW resp_valid arrives 2 cycles after accept and mem_write pulses exactly once.
- After the above, LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088; LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABC.
- SB 0x11 data 0x55, then LW 0x10 -> 0x8899 55BC (0x889955BC). SH 0x12 data 0x1234, then LW 0x10 -> 0x123455BC. Each store shows one RMW_RD read followed by one write.
- LW 0x400 (MEM_WORDS=256), or LD funct3=3 -> resp_err=1 one cycle after accept, and mem_read/mem_write stay 0.
- LH 0x11 with LSU_MISALIGN_TRAP_EN -> resp_err=1, no access. Without it -> LH behaves as 0x10.
- Assert rst during the WR cycle of SB 0x20 -> no write occurs, a later LW 0x20 returns 0, and req_ready=1 the cycle after reset.
